// File: rtl/pattern_feeder.sv
// pattern_feeder: walks a character buffer through the pattern matcher,
// one reset/x/rdy/y handshake per character, reporting match positions.
module pattern_feeder #(
    parameter int DEPTH   = 13,
    parameter int ADDR_W  = 4,
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              pm_reset,
    output logic [7:0]        pm_x,
    input  logic              pm_rdy,
    input  logic              pm_y,
    output logic              match_valid,
    output logic [ADDR_W-1:0] match_pos,
    input  logic              match_ready,
    output logic [ADDR_W:0]   match_count,
    output logic              timeout_err
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_REPORT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [TW-1:0]     wait_q, wait_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              terr_q, terr_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        mem_q [DEPTH];

    logic [ADDR_W:0]   len_clamp;
    logic [ADDR_W-1:0] idx_nx;
    logic              last;
    logic              adv;

    assign len_clamp = (len > DEPTH_C) ? DEPTH_C : len;
    assign idx_nx    = idx_q + 1'b1;
    assign last      = ({1'b0, idx_q} == (len_q - 1'b1));

    assign busy        = (state_q == S_LOAD) || (state_q == S_WAIT)
                      || (state_q == S_REPORT);
    assign done        = (state_q == S_DONE);
    assign pm_reset    = (state_q != S_WAIT);
    assign pm_x        = x_q;
    assign match_valid = (state_q == S_REPORT);
    assign match_pos   = match_valid ? idx_q : '0;
    assign match_count = cnt_q;
    assign timeout_err = terr_q;

    // Buffer write port; frozen while a scan is in flight, not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && ({1'b0, wr_addr} < DEPTH_C)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Scan sequencing: per-character load/hold, wait for rdy, report.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        hold_d  = hold_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        x_d     = x_q;
        adv     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d = len_clamp;
                    idx_d = '0;
                    if (len_clamp == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        terr_d  = 1'b0;
                        hold_d  = '0;
                        x_d     = mem_q[0];
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (hold_q == HW'(HOLD - 1)) begin
                    wait_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (pm_rdy) begin
                    if (pm_y) state_d = S_REPORT;
                    else      adv     = 1'b1;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    terr_d = 1'b1;
                    adv    = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_REPORT: begin
                if (match_ready) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    adv = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (adv) begin
            if (last) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_nx;
                x_d     = mem_q[idx_nx];
                hold_d  = '0;
                state_d = S_LOAD;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            hold_q  <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            x_q     <= x_d;
        end
    end

endmodule

// File: tb/tb_pattern_feeder.sv
// tb_pattern_feeder: randomized scans against a behavioural matcher and
// an expected-result model computed from buffer, delays and target.
module tb_pattern_feeder;

    localparam int DEPTH   = 13;
    localparam int ADDR_W  = 4;
    localparam int HOLD    = 2;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 255;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, done, pm_reset;
    logic [7:0]        pm_x;
    logic              pm_rdy = 1'b0;
    logic              pm_y = 1'b0;
    logic              match_valid;
    logic [ADDR_W-1:0] match_pos;
    logic              match_ready = 1'b0;
    logic [ADDR_W:0]   match_count;
    logic              timeout_err;

    pattern_feeder #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len),
        .busy(busy), .done(done),
        .pm_reset(pm_reset), .pm_x(pm_x),
        .pm_rdy(pm_rdy), .pm_y(pm_y),
        .match_valid(match_valid), .match_pos(match_pos),
        .match_ready(match_ready),
        .match_count(match_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_m [16];
    int         dly [DEPTH];
    logic [7:0] target;
    int         rmode = 0;
    int         last_cnt = 0;
    bit         last_te = 1'b0;

    int   ord = 0, cidx = 0, wcnt = 0, hold_cnt = 0;
    int   busy_cyc = 0, stall_cyc = 0, done_cnt = 0, stall_run = 0;
    bit   prev_rst = 1'b1, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [ADDR_W-1:0] prev_pos = '0;
    logic [7:0]        prev_x = '0;
    int   acc_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Matcher model and result consumer, both acting on the falling edge.
    always @(negedge clk) begin
        bit nr;
        if (prev_valid && !prev_ready) begin
            chk("stall_valid", match_valid, 1);
            chk("stall_pos", match_pos, prev_pos);
            chk("stall_x", pm_x, prev_x);
        end
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        case (rmode)
            0:       nr = 1'b1;
            1:       nr = 1'($urandom);
            default: nr = !(match_valid && stall_run < 5);
        endcase
        if (match_valid) begin
            if (nr) begin
                acc_q.push_back(int'(match_pos));
                stall_run = 0;
            end else begin
                stall_cyc++;
                stall_run++;
            end
        end else begin
            stall_run = 0;
        end
        match_ready = nr;
        prev_valid  = match_valid;
        prev_ready  = nr;
        prev_pos    = match_pos;
        prev_x      = pm_x;
        if (!pm_reset) begin
            if (prev_rst) begin
                cidx = (ord < DEPTH) ? ord : DEPTH - 1;
                chk("hold_len", hold_cnt, HOLD);
                chk("pm_x", pm_x, mem_m[cidx]);
                ord++;
                wcnt = 0;
            end else begin
                wcnt++;
            end
            pm_rdy = (wcnt >= dly[cidx]);
            pm_y   = pm_rdy ? (pm_x == target) : 1'($urandom);
            hold_cnt = 0;
        end else begin
            hold_cnt = (busy && !match_valid) ? hold_cnt + 1 : 0;
            pm_rdy = 1'($urandom);
            pm_y   = 1'($urandom);
        end
        prev_rst = pm_reset;
    end

    task automatic wr(input int a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < DEPTH) mem_m[a] = d;
    endtask

    task automatic run_scan(input int L, input bit poke);
        int lc;
        int exp_q[$];
        int base;
        int nm;
        bit te;
        int ecnt;
        bit ete;
        int k;
        lc   = (L > DEPTH) ? DEPTH : L;
        base = 0;
        nm   = 0;
        te   = 1'b0;
        for (int i = 0; i < lc; i++) begin
            if (dly[i] >= TIMEOUT) begin
                te = 1'b1;
                base += HOLD + TIMEOUT;
            end else begin
                base += HOLD + dly[i] + 1;
                if (mem_m[i] == target) begin
                    exp_q.push_back(i);
                    nm++;
                end
            end
        end
        ecnt = (lc == 0) ? last_cnt : nm;
        ete  = (lc == 0) ? last_te : te;
        @(negedge clk);
        start = 1'b1;
        len   = (ADDR_W+1)'(L);
        ord   = 0;
        acc_q.delete();
        busy_cyc  = 0;
        stall_cyc = 0;
        done_cnt  = 0;
        @(negedge clk);
        start = 1'b0;
        if (lc == 0) begin
            chk("len0_done", done, 1);
            chk("len0_busy", busy, 0);
        end else begin
            chk("lat_busy", busy, 1);
            chk("lat_x", pm_x, mem_m[0]);
            chk("lat_rst", pm_reset, 1);
        end
        k = 0;
        while (!done && k < 20000) begin
            @(negedge clk);
            k++;
            if (poke && k == 4) begin
                start   = 1'b1;
                len     = 1;
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = ~mem_m[0];
            end else if (k == 5) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("count", match_count, ecnt);
        chk("terr", timeout_err, ete);
        chk("chars", ord, lc);
        chk("ndone", done_cnt, 1);
        chk("nmatch", acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            chk("pos", acc_q[i], exp_q[i]);
        chk("cycles", busy_cyc, (lc == 0) ? 0 : base + nm + stall_cyc);
        last_cnt = ecnt;
        last_te  = ete;
    endtask

    task automatic set_dly(input int d);
        for (int i = 0; i < DEPTH; i++) dly[i] = d;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        logic [7:0] s [5];
        s = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62};
        set_dly(3);
        target = 8'h62;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pmrst", pm_reset, 1);
        chk("rst_x", pm_x, 0);
        chk("rst_valid", match_valid, 0);
        chk("rst_pos", match_pos, 0);
        chk("rst_cnt", match_count, 0);
        chk("rst_terr", timeout_err, 0);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            wr(i, (i < 5) ? s[i] : 8'($urandom_range(8'h63, 8'h7a)));

        rmode = 0;
        run_scan(5, 0);
        rmode = 2;
        run_scan(5, 0);
        rmode = 0;
        dly[2] = NEVER;
        run_scan(4, 0);
        set_dly(3);
        dly[1] = TIMEOUT - 1;
        dly[2] = TIMEOUT;
        run_scan(3, 0);
        run_scan(0, 0);
        for (int i = 0; i < DEPTH; i++) dly[i] = $urandom_range(0, 6);
        rmode = 1;
        run_scan(20, 0);

        set_dly(3);
        dly[2] = 20;
        @(negedge clk);
        start = 1'b1;
        len   = 5;
        ord   = 0;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(ord == 3 && !pm_reset) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reach_wait2", ord, 3);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_pmrst", pm_reset, 1);
        chk("mid_valid", match_valid, 0);
        chk("mid_cnt", match_count, 0);
        chk("mid_terr", timeout_err, 0);
        chk("mid_x", pm_x, 0);
        reset = 1'b1;
        last_cnt = 0;
        last_te  = 1'b0;
        set_dly(3);
        run_scan(5, 0);

        run_scan(5, 1);
        run_scan(13, 0);

        for (int t = 0; t < 25; t++) begin
            int L;
            repeat ($urandom_range(0, 4))
                wr($urandom_range(0, 15), 8'($urandom_range(8'h61, 8'h64)));
            target = ($urandom_range(0, 3) == 0)
                   ? 8'($urandom) : mem_m[$urandom_range(0, DEPTH - 1)];
            for (int i = 0; i < DEPTH; i++) begin
                case ($urandom_range(0, 9))
                    0:       dly[i] = NEVER;
                    1:       dly[i] = TIMEOUT - 1;
                    2:       dly[i] = TIMEOUT;
                    default: dly[i] = $urandom_range(0, 8);
                endcase
            end
            rmode = $urandom_range(0, 2);
            L = $urandom_range(0, 20);
            run_scan(L, (L >= 3) && ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_feeder.md
# pattern_feeder

Synthesizable initiator for the `pattern` matcher interface (`reset`/`x` in, `rdy`/`y` out). It holds a loadable 8-bit character buffer and presents one character at a time to the matcher. For each character it pulses the matcher reset, waits for `rdy`, samples `y`, and reports matching positions through a valid/ready result port. It replaces the simulation-only feeding loop so that matching can run on silicon.

## Interface
Parameters:
- `DEPTH`, 13: character buffer entries.
- `ADDR_W`, 4: index width; must satisfy 2^ADDR_W ≥ DEPTH.
- `HOLD`, 2: cycles `pm_reset` stays high per character; must be ≥ 1.
- `TIMEOUT`, 64: maximum cycles spent waiting for `pm_rdy` per character.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `wr_en` in 1: buffer write strobe. Ignored while `busy`.
- `wr_addr` in ADDR_W: buffer write index. Writes with `wr_addr` ≥ DEPTH are ignored.
- `wr_data` in 8: character to write.
- `start` in 1: begin a scan. Sampled only in IDLE.
- `len` in ADDR_W+1: number of characters to scan, indices 0..len-1. Values above DEPTH are clamped to DEPTH.
- `busy` out 1: high from the cycle after `start` is accepted until DONE.
- `done` out 1: one-cycle pulse when a scan completes.
- `pm_reset` out 1: active-high reset to the matcher.
- `pm_x` out 8: character presented to the matcher.
- `pm_rdy` in 1: matcher result valid.
- `pm_y` in 1: matcher match flag.
- `match_valid` out 1: a match position is available.
- `match_pos` out ADDR_W: index of the matching character.
- `match_ready` in 1: downstream accepts the result.
- `match_count` out ADDR_W+1: matches reported in the current or last scan.
- `timeout_err` out 1: sticky; set when any character in the scan timed out.

## Operation
The block is a state machine with states IDLE, LOAD, WAIT, REPORT and DONE.

- **IDLE**
  - `pm_reset`=1 and `busy`=0.
  - Buffer writes are accepted.
  - On `start`: latch the clamped `len` and set idx=0.
  - If the clamped `len`=0, go directly to DONE. Otherwise clear `match_count` and `timeout_err` and go to LOAD.
- **LOAD**
  - `pm_x` = mem[idx]. `pm_x` holds this value through LOAD, WAIT and REPORT.
  - `pm_reset`=1 for exactly HOLD cycles, then go to WAIT.
  - `pm_rdy` is ignored in LOAD.
- **WAIT**
  - `pm_reset`=0. The wait counter starts at 0 on entry.
  - On the first cycle `pm_rdy`=1, sample `pm_y`. If `pm_y`=1, go to REPORT. If `pm_y`=0, advance.
  - If the counter reaches TIMEOUT-1 without `pm_rdy`, set `timeout_err`, treat the character as no match, and advance.
- **REPORT**
  - `match_valid`=1 and `match_pos`=idx, both stable until accepted.
  - On `match_valid`&&`match_ready`: increment `match_count` in that cycle and advance.
- **Advance**
  - If idx = len-1, go to DONE. Otherwise increment idx and go to LOAD.
- **DONE**
  - One cycle: `done`=1, `busy`=0, `pm_reset`=1.
  - Go to IDLE.

Arithmetic:
- `match_count` saturates at 2^(ADDR_W+1)-1.
- idx never wraps beyond len-1.

## Timing
Reset values:
- `busy`=0, `done`=0, `pm_reset`=1, `pm_x`=0, `match_valid`=0, `match_pos`=0, `match_count`=0, `timeout_err`=0.
- State is IDLE.
- Buffer contents are not cleared by reset.

Latency:
- `start` accepted at edge N: `busy`=1 and LOAD begin at N+1.
- The first `pm_x` is valid at N+1.
- `pm_reset` falls at N+1+HOLD.
- Per-character cost with no match: HOLD + (cycles until `pm_rdy`) + 0. The advance happens on the same edge that samples `pm_rdy`.
- With a match, add one cycle for REPORT plus any downstream stall.

Boundary conditions:
- `start` while busy: ignored.
- `wr_en` while busy: ignored. Buffer contents are stable during a scan.
- `pm_rdy` and timeout on the same cycle: `pm_rdy` wins and there is no error.
- `match_ready` held high permanently: REPORT lasts exactly one cycle.
- `reset` low mid-scan: next edge goes to IDLE with all outputs at reset values. A pending match is dropped.
- `start` and `reset` low on the same edge: reset wins.

## Test plan
- **Basic scan.** Load "abcab" at indices 0..4. Matcher model asserts `y` on 'b' with `rdy` 3 cycles after `pm_reset` falls. Pulse `start`, `len`=5, `match_ready`=1. Required: `match_pos` 1 then 4, `match_count`=2, one `done` pulse, `timeout_err`=0.
- **Backpressure.** Same as the basic scan with `match_ready`=0 for 5 cycles after the first `match_valid`. Required: `match_valid`/`match_pos`=1 held stable, `pm_x`='b' held, no idx advance until accept.
- **Timeout.** Matcher never asserts `rdy` for index 2, `len`=4, TIMEOUT=64. Required: after 64 WAIT cycles `timeout_err`=1, scan continues to index 3, `done` pulses.
- **Edge lengths.** `len`=0 → `done` on the cycle after `start` with zero `pm_reset` low periods. `len`=20 with DEPTH=13 → exactly 13 characters presented, last `pm_x`=mem[12].
- **Reset mid-scan.** Drive `reset` low during WAIT of index 2. Required: next edge `busy`=0, `pm_reset`=1, `match_valid`=0, `match_count`=0. A new `start` rescans from index 0 with buffer contents intact.
- **Ignored inputs.** `start` and `wr_en` pulsed during a scan. Required: no restart and no buffer change; a readback scan shows the original characters.
